fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and drives the icache request (imemREN/imemaddr), holding the address stable until ihit.
- Presents the fetched word, its PC and PC+4 to IF/ID with a write enable.
- Absorbs downstream stalls with a 1-entry hold buffer and applies branch/jump redirects from EX/MEM, discarding wrong-path data.

Parameters:
PC_INIT, 32'h0000_0000, PC value after reset
HALT_WORD, 32'hFFFF_FFFF, encoding of HALT; fetch stops after delivering it

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
ihit  in  1  icache returns imemload for imemaddr this cycle
imemload  in  32  instruction word from icache
imemREN  out  1  icache read request
imemaddr  out  32  icache read address (= pc)
stall  in  1  IF/ID must not be written this cycle (hazard unit)
redirect_valid  in  1  one-cycle pulse: taken branch/jump resolved
redirect_addr  in  32  redirect target; bits [1:0] ignored, forced 0
ifid_wen  out  1  write enable to IF/ID
instruction_out  out  32  instruction to IF/ID
pcn_out  out  32  address of instruction_out
next_address_out  out  32  pcn_out + 4, mod 2^32
halted  out  1  fetch has stopped on HALT_WORD

Behaviour:
- Reset (async, nRST low): pc=PC_INIT, state=FETCH, buf_instr=0, buf_pc=0, tgt=0. While nRST low, all outputs are 0.
- Registered state: pc, state {FETCH, DISCARD, HOLD, HALTED}, buf_instr, buf_pc, tgt.
- Outputs are combinational from state and inputs. imemaddr=pc always. imemREN=1 in FETCH and DISCARD, 0 in HOLD and HALTED.
- FETCH:
  - ihit=0, redirect=0: wait; pc is held.
  - ihit=0, redirect=1: tgt<=redirect_addr; go to DISCARD. pc is unchanged so the request stays stable.
  - ihit=1, redirect=1: drop the word; pc<=redirect_addr; stay in FETCH; ifid_wen=0. Redirect has priority over delivery.
  - ihit=1, redirect=0, stall=0: ifid_wen=1, instruction_out=imemload, pcn_out=pc, next_address_out=pc+4; pc<=pc+4. If imemload==HALT_WORD, go to HALTED, else stay in FETCH.
  - ihit=1, redirect=0, stall=1: buf_instr<=imemload, buf_pc<=pc; pc<=pc+4; go to HOLD; ifid_wen=0.
- DISCARD:
  - imemREN stays 1 at the old pc until ihit.
  - On ihit: drop the word; pc<=tgt; go to FETCH.
  - A further redirect in DISCARD overwrites tgt (latest wins). If it coincides with ihit, pc<=redirect_addr.
  - ifid_wen=0 throughout.
- HOLD:
  - Outputs present the buffer: instruction_out=buf_instr, pcn_out=buf_pc, next_address_out=buf_pc+4.
  - redirect=1: drop the buffer; pc<=redirect_addr; go to FETCH; ifid_wen=0.
  - stall=0: ifid_wen=1; go to HALTED if buf_instr==HALT_WORD, else FETCH.
  - stall=1: remain in HOLD with ifid_wen=0.
- HALTED:
  - halted=1, imemREN=0, ifid_wen=0.
  - redirect=1 (HALT was on the wrong path): pc<=redirect_addr; go to FETCH.
  - Otherwise remain until reset.
- Outputs when ifid_wen=0: instruction_out/pcn_out/next_address_out are don't-care outside HOLD. The bench must only check them when ifid_wen=1.
- Throughput and wrap:
  - Throughput is 1 instruction per cycle when ihit=1 and stall=0 continuously.
  - Fetch-to-IF/ID latency is 0 cycles (same cycle as ihit).
  - pc+4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
- Reset mid-operation clears the buffer and any pending tgt. Fetch restarts at PC_INIT on the first edge after nRST rises.

Test Plan:
- Reset, ihit tied 1, imemload=32'h2001_0005, stall=0 -> imemaddr 0,4,8 on consecutive cycles; ifid_wen=1 each cycle; pcn_out=0,4,8; next_address_out=4,8,C.
- Miss: ihit=0 for 3 cycles at pc=8, then 1 -> imemaddr holds 8 for 4 cycles; single ifid_wen pulse with pcn_out=8.
- Stall: ihit=1 at pc=10 with stall=1 for 2 cycles, then 0 -> imemREN=0 during HOLD; ifid_wen=1 on the release cycle with pcn_out=10 and buffered word; next fetch at 14.
- Redirect during miss: pc=20, ihit=0, redirect_valid=1 with redirect_addr=32'h0000_0103; ihit arrives 2 cycles later -> that word is dropped, no ifid_wen; next imemaddr=32'h100.
- Halt: imemload=HALT_WORD at pc=40 -> delivered with ifid_wen=1; halted=1 and imemREN=0 thereafter. A redirect to 80 then resumes fetch at 80 with halted=0.
- Wrap and async reset: PC_INIT=32'hFFFF_FFFC -> next_address_out=0, next imemaddr=0. Assert nRST low mid-HOLD -> all outputs 0 immediately; restart at PC_INIT.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage, the instruction cache, the hazard
// unit / EX-MEM redirect source, and the IF/ID pipeline register.
// The master modport is the fetch stage itself; slave is its environment.
interface fetch_stage_if;
    // icache side
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;

    // hazard unit and redirect source
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;

    // IF/ID side
    logic        ifid_wen;
    logic [31:0] instruction_out;
    logic [31:0] pcn_out;
    logic [31:0] next_address_out;
    logic        halted;

    modport master (
        input  ihit,
        input  imemload,
        input  stall,
        input  redirect_valid,
        input  redirect_addr,
        output imemREN,
        output imemaddr,
        output ifid_wen,
        output instruction_out,
        output pcn_out,
        output next_address_out,
        output halted
    );

    modport slave (
        output ihit,
        output imemload,
        output stall,
        output redirect_valid,
        output redirect_addr,
        input  imemREN,
        input  imemaddr,
        input  ifid_wen,
        input  instruction_out,
        input  pcn_out,
        input  next_address_out,
        input  halted
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Owns the PC, issues icache reads (address held
// stable until ihit), delivers words to IF/ID in the ihit cycle, parks one
// word in a hold buffer when IF/ID is stalled, and honours branch/jump
// redirects by discarding wrong-path data. Stops after delivering HALT_WORD.
module fetch_stage #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_stage_if.master fs
);

    // FETCH  : request outstanding at pc, deliver on ihit
    // DISCARD: redirect arrived during a miss; wait out the stale request
    // HOLD   : a word was fetched while IF/ID was stalled; present the buffer
    // HALTED : HALT delivered, no more requests until redirect or reset
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] tgt_q, tgt_d;

    // Internal (ungated) output values; forced to zero while reset is held.
    logic        imem_ren_c;
    logic        ifid_wen_c;
    logic [31:0] instr_c;
    logic [31:0] pcn_c;
    logic        halted_c;

    logic [31:0] redir_tgt;
    logic [31:0] pc_plus4;
    logic        load_is_halt;
    logic        buf_is_halt;

    // Redirect targets are word aligned: the two low bits are simply dropped.
    assign redir_tgt    = fs.redirect_addr & 32'hFFFF_FFFC;
    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
    assign pc_plus4     = pc_q + 32'd4;
    assign load_is_halt = (fs.imemload == HALT_WORD);
    assign buf_is_halt  = (buf_instr_q == HALT_WORD);

    // State register with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= FETCH;
            pc_q        <= PC_INIT;
            buf_instr_q <= 32'd0;
            buf_pc_q    <= 32'd0;
            tgt_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            tgt_q       <= tgt_d;
        end
    end

    // Next-state and output decode; redirect always beats delivery.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        tgt_d       = tgt_q;

        imem_ren_c  = 1'b0;
        ifid_wen_c  = 1'b0;
        instr_c     = fs.imemload;
        pcn_c       = pc_q;
        halted_c    = 1'b0;

        case (state_q)
            FETCH: begin
                imem_ren_c = 1'b1;
                if (fs.redirect_valid) begin
                    if (fs.ihit) begin
                        // Request already returned: jump straight away.
                        pc_d = redir_tgt;
                    end else begin
                        // Keep the outstanding request stable; jump later.
                        tgt_d   = redir_tgt;
                        state_d = DISCARD;
                    end
                end else if (fs.ihit) begin
                    pc_d = pc_plus4;
                    if (fs.stall) begin
                        buf_instr_d = fs.imemload;
                        buf_pc_d    = pc_q;
                        state_d     = HOLD;
                    end else begin
                        ifid_wen_c = 1'b1;
                        if (load_is_halt) begin
                            state_d = HALTED;
                        end
                    end
                end
            end

            DISCARD: begin
                imem_ren_c = 1'b1;
                if (fs.redirect_valid) begin
                    tgt_d = redir_tgt;
                end
                if (fs.ihit) begin
                    // Stale word dropped; the newest target wins.
                    pc_d    = fs.redirect_valid ? redir_tgt : tgt_q;
                    state_d = FETCH;
                end
            end

            HOLD: begin
                instr_c = buf_instr_q;
                pcn_c   = buf_pc_q;
                if (fs.redirect_valid) begin
                    pc_d    = redir_tgt;
                    state_d = FETCH;
                end else if (!fs.stall) begin
                    ifid_wen_c = 1'b1;
                    state_d    = buf_is_halt ? HALTED : FETCH;
                end
            end

            HALTED: begin
                halted_c = 1'b1;
                if (fs.redirect_valid) begin
                    // The HALT was on a wrong path; resume at the target.
                    pc_d    = redir_tgt;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Drive the bus; everything reads as zero while reset is asserted.
    always_comb begin
        fs.imemREN          = 1'b0;
        fs.imemaddr         = 32'd0;
        fs.ifid_wen         = 1'b0;
        fs.instruction_out  = 32'd0;
        fs.pcn_out          = 32'd0;
        fs.next_address_out = 32'd0;
        fs.halted           = 1'b0;
        if (nRST) begin
            fs.imemREN          = imem_ren_c;
            fs.imemaddr         = pc_q;
            fs.ifid_wen         = ifid_wen_c;
            fs.instruction_out  = instr_c;
            fs.pcn_out          = pcn_c;
            fs.next_address_out = pcn_c + 32'd4;
            fs.halted           = halted_c;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic CLK = 1'b0;
    logic nRST;

    always #5 CLK = ~CLK;

    fetch_stage_if fif ();
    fetch_stage_if wif ();

    fetch_stage #(
        .PC_INIT   (32'h0000_0000),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .fs   (fif)
    );

    // Second copy starting at the top of the address space for the wrap case.
    fetch_stage #(
        .PC_INIT   (32'hFFFF_FFFC),
        .HALT_WORD (32'hFFFF_FFFF)
    ) u_wrap (
        .CLK  (CLK),
        .nRST (nRST),
        .fs   (wif)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_pc;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    // Scoreboard: every IF/ID write must match the oldest expected delivery.
    always @(negedge CLK) begin
        if (nRST === 1'b1 && fif.ifid_wen === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_wen: got ifid_wen=1 pcn_out=%h instr=%h, required no write",
                         fif.pcn_out, fif.instruction_out);
            end else begin
                mon_e = sb.pop_front();
                if (fif.instruction_out !== mon_e.instr || fif.pcn_out !== mon_e.pc ||
                    fif.next_address_out !== mon_e.pc + 32'd4) begin
                    bad++;
                    $display("FAIL sb_delivery: got instr=%h pcn=%h next=%h, required instr=%h pcn=%h next=%h",
                             fif.instruction_out, fif.pcn_out, fif.next_address_out,
                             mon_e.instr, mon_e.pc, mon_e.pc + 32'd4);
                end else begin
                    $display("deliver pc=%h instr=%h ok", mon_e.pc, mon_e.instr);
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        fif.ihit           = 1'b0;
        fif.stall          = 1'b0;
        fif.redirect_valid = 1'b0;
        fif.redirect_addr  = 32'd0;
        fif.imemload       = 32'd0;
    endtask

    // n back-to-back hits with no stall: one delivery per cycle.
    task automatic deliver(input int n, input logic [31:0] base);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            fif.ihit           = 1'b1;
            fif.stall          = 1'b0;
            fif.redirect_valid = 1'b0;
            fif.imemload       = base + 32'(i);
            e.pc    = exp_pc;
            e.instr = base + 32'(i);
            sb.push_back(e);
            @(negedge CLK);
            total++;
            if (fif.imemaddr !== exp_pc || fif.imemREN !== 1'b1) begin
                bad++;
                $display("FAIL deliver_req: got imemaddr=%h imemREN=%b, required %h 1",
                         fif.imemaddr, fif.imemREN, exp_pc);
            end
            next_cycle();
            exp_pc = exp_pc + 32'd4;
        end
        fif.ihit = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        wif.ihit = 1'b0; wif.stall = 1'b0; wif.redirect_valid = 1'b0;
        wif.redirect_addr = 32'd0; wif.imemload = 32'd0;
        nRST = 1'b0;
        #2;
        total++;
        if ({fif.imemREN, fif.imemaddr, fif.ifid_wen, fif.instruction_out, fif.pcn_out,
             fif.next_address_out, fif.halted} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ren=%b addr=%h wen=%b halted=%b, required all 0",
                     fif.imemREN, fif.imemaddr, fif.ifid_wen, fif.halted);
        end
        next_cycle();
        nRST = 1'b1;
        #1;
        total++;
        if (fif.imemaddr !== 32'h0 || fif.imemREN !== 1'b1 || fif.halted !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got addr=%h ren=%b halted=%b, required 0 1 0",
                     fif.imemaddr, fif.imemREN, fif.halted);
        end
        $display("reset released, fetch at %h", fif.imemaddr);
        exp_pc = 32'h0;
    endtask

    task automatic test_miss();
        for (int i = 0; i < 3; i++) begin
            fif.ihit = 1'b0;
            @(negedge CLK);
            total++;
            if (fif.imemaddr !== exp_pc || fif.imemREN !== 1'b1 || fif.ifid_wen !== 1'b0) begin
                bad++;
                $display("FAIL miss_hold: got addr=%h ren=%b wen=%b, required %h 1 0",
                         fif.imemaddr, fif.imemREN, fif.ifid_wen, exp_pc);
            end
            next_cycle();
        end
        deliver(1, 32'h2002_0008);
    endtask

    task automatic test_stall();
        exp_t        e;
        logic [31:0] w;
        logic [31:0] spc;
        w   = 32'hA5A5_0010;
        spc = exp_pc;
        fif.ihit = 1'b1; fif.stall = 1'b1; fif.imemload = w;
        e.pc = spc; e.instr = w;
        sb.push_back(e);
        @(negedge CLK);
        total++;
        if (fif.ifid_wen !== 1'b0) begin
            bad++;
            $display("FAIL stall_no_wen: got ifid_wen=%b, required 0", fif.ifid_wen);
        end
        next_cycle();
        fif.imemload = 32'h1111_1111;
        @(negedge CLK);
        total++;
        if (fif.imemREN !== 1'b0 || fif.ifid_wen !== 1'b0 || fif.instruction_out !== w ||
            fif.pcn_out !== spc || fif.imemaddr !== spc + 32'd4) begin
            bad++;
            $display("FAIL stall_hold: got ren=%b wen=%b instr=%h pcn=%h addr=%h, required 0 0 %h %h %h",
                     fif.imemREN, fif.ifid_wen, fif.instruction_out, fif.pcn_out, fif.imemaddr,
                     w, spc, spc + 32'd4);
        end
        next_cycle();
        fif.stall = 1'b0; fif.ihit = 1'b0;
        @(negedge CLK);
        total++;
        if (fif.imemREN !== 1'b0 || fif.ifid_wen !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: got ren=%b wen=%b, required 0 1", fif.imemREN, fif.ifid_wen);
        end
        next_cycle();
        exp_pc = spc + 32'd4;
        deliver(1, 32'h2003_0014);
    endtask

    // Shared shape for cycles where nothing may reach IF/ID.
    task automatic test_redirect_miss();
        logic [31:0] old_pc;
        old_pc = exp_pc;
        fif.ihit = 1'b0; fif.redirect_valid = 1'b1; fif.redirect_addr = 32'h0000_0103;
        @(negedge CLK);
        total++;
        if (fif.ifid_wen !== 1'b0 || fif.imemaddr !== old_pc) begin
            bad++;
            $display("FAIL redir_miss_req: got wen=%b addr=%h, required 0 %h", fif.ifid_wen, fif.imemaddr, old_pc);
        end
        next_cycle();
        fif.redirect_valid = 1'b0;
        @(negedge CLK);
        total++;
        if (fif.imemREN !== 1'b1 || fif.imemaddr !== old_pc || fif.ifid_wen !== 1'b0) begin
            bad++;
            $display("FAIL redir_discard: got ren=%b addr=%h wen=%b, required 1 %h 0",
                     fif.imemREN, fif.imemaddr, fif.ifid_wen, old_pc);
        end
        next_cycle();
        fif.ihit = 1'b1; fif.imemload = 32'hDEAD_BEEF;
        @(negedge CLK);
        total++;
        if (fif.ifid_wen !== 1'b0) begin
            bad++;
            $display("FAIL redir_drop: got wen=%b, required 0", fif.ifid_wen);
        end
        next_cycle();
        fif.ihit = 1'b0;
        exp_pc = 32'h0000_0100;
        deliver(1, 32'h2004_0100);
    endtask

    task automatic test_redirect_latest_and_hit();
        // Two redirects during a miss: the second target must win.
        fif.ihit = 1'b0; fif.redirect_valid = 1'b1; fif.redirect_addr = 32'h0000_0200;
        next_cycle();
        fif.redirect_addr = 32'h0000_0300;
        next_cycle();
        fif.redirect_valid = 1'b0; fif.ihit = 1'b1; fif.imemload = 32'hBAD0_0001;
        @(negedge CLK);
        total++;
        if (fif.ifid_wen !== 1'b0) begin
            bad++;
            $display("FAIL latest_drop: got wen=%b, required 0", fif.ifid_wen);
        end
        next_cycle();
        exp_pc = 32'h0000_0300;
        // Redirect together with a hit: word dropped, low bits ignored.
        fif.ihit = 1'b1; fif.redirect_valid = 1'b1; fif.redirect_addr = 32'h0000_003D;
        fif.imemload = 32'hBAD0_0002;
        @(negedge CLK);
        total++;
        if (fif.ifid_wen !== 1'b0 || fif.imemaddr !== 32'h300) begin
            bad++;
            $display("FAIL hit_redirect: got wen=%b addr=%h, required 0 00000300", fif.ifid_wen, fif.imemaddr);
        end
        next_cycle();
        fif.redirect_valid = 1'b0;
        exp_pc = 32'h0000_003C;
        deliver(1, 32'h2005_003C);
    endtask

    task automatic test_halt();
        exp_t e;
        fif.ihit = 1'b1; fif.stall = 1'b0; fif.imemload = HALT;
        e.pc = exp_pc; e.instr = HALT;
        sb.push_back(e);
        @(negedge CLK);
        total++;
        if (fif.imemaddr !== 32'h40 || fif.halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_fetch: got addr=%h halted=%b, required 00000040 0", fif.imemaddr, fif.halted);
        end
        next_cycle();
        fif.imemload = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            total++;
            if (fif.halted !== 1'b1 || fif.imemREN !== 1'b0 || fif.ifid_wen !== 1'b0) begin
                bad++;
                $display("FAIL halted_state: got halted=%b ren=%b wen=%b, required 1 0 0",
                         fif.halted, fif.imemREN, fif.ifid_wen);
            end
            next_cycle();
        end
        fif.ihit = 1'b0; fif.redirect_valid = 1'b1; fif.redirect_addr = 32'h0000_0080;
        next_cycle();
        fif.redirect_valid = 1'b0;
        total++;
        if (fif.halted !== 1'b0 || fif.imemaddr !== 32'h80 || fif.imemREN !== 1'b1) begin
            bad++;
            $display("FAIL halt_resume: got halted=%b addr=%h ren=%b, required 0 00000080 1",
                     fif.halted, fif.imemaddr, fif.imemREN);
        end
        exp_pc = 32'h0000_0080;
        deliver(4, 32'h3000_0080);
    endtask

    task automatic test_hold_redirect_and_halt();
        exp_t e;
        // Buffer dropped by a redirect while held.
        fif.ihit = 1'b1; fif.stall = 1'b1; fif.imemload = 32'hBAD0_0003;
        next_cycle();
        fif.ihit = 1'b0; fif.stall = 1'b0; fif.redirect_valid = 1'b1; fif.redirect_addr = 32'h0000_0500;
        @(negedge CLK);
        total++;
        if (fif.ifid_wen !== 1'b0) begin
            bad++;
            $display("FAIL hold_redirect: got wen=%b, required 0", fif.ifid_wen);
        end
        next_cycle();
        fif.redirect_valid = 1'b0;
        exp_pc = 32'h0000_0500;
        deliver(1, 32'h2006_0500);
        // HALT released from the hold buffer must still halt fetch.
        fif.ihit = 1'b1; fif.stall = 1'b1; fif.imemload = HALT;
        e.pc = exp_pc; e.instr = HALT;
        sb.push_back(e);
        next_cycle();
        fif.ihit = 1'b0; fif.stall = 1'b0;
        next_cycle();
        total++;
        if (fif.halted !== 1'b1 || fif.imemREN !== 1'b0) begin
            bad++;
            $display("FAIL hold_halt: got halted=%b ren=%b, required 1 0", fif.halted, fif.imemREN);
        end
        fif.redirect_valid = 1'b1; fif.redirect_addr = 32'h0000_0600;
        next_cycle();
        fif.redirect_valid = 1'b0;
        exp_pc = 32'h0000_0600;
        deliver(1, 32'h2007_0600);
    endtask

    task automatic test_wrap_reset();
        wif.ihit = 1'b1; wif.stall = 1'b0; wif.redirect_valid = 1'b0; wif.imemload = 32'h1234_5678;
        @(negedge CLK);
        total++;
        if (wif.ifid_wen !== 1'b1 || wif.pcn_out !== 32'hFFFF_FFFC || wif.next_address_out !== 32'h0 ||
            wif.instruction_out !== 32'h1234_5678) begin
            bad++;
            $display("FAIL wrap_deliver: got wen=%b pcn=%h next=%h instr=%h, required 1 fffffffc 00000000 12345678",
                     wif.ifid_wen, wif.pcn_out, wif.next_address_out, wif.instruction_out);
        end
        next_cycle();
        wif.ihit = 1'b0;
        total++;
        if (wif.imemaddr !== 32'h0) begin
            bad++;
            $display("FAIL wrap_addr: got imemaddr=%h, required 00000000", wif.imemaddr);
        end
        // Enter HOLD, then pull reset mid-cycle.
        fif.ihit = 1'b1; fif.stall = 1'b1; fif.imemload = 32'hBAD0_0004;
        next_cycle();
        fif.ihit = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        total++;
        if ({fif.imemREN, fif.imemaddr, fif.ifid_wen, fif.instruction_out, fif.pcn_out,
             fif.next_address_out, fif.halted, wif.imemREN, wif.imemaddr, wif.halted} !== '0) begin
            bad++;
            $display("FAIL async_reset: got ren=%b addr=%h wen=%b instr=%h wrap_addr=%h, required all 0",
                     fif.imemREN, fif.imemaddr, fif.ifid_wen, fif.instruction_out, wif.imemaddr);
        end
        next_cycle();
        nRST = 1'b1;
        fif.stall = 1'b0;
        #1;
        total++;
        if (fif.imemaddr !== 32'h0 || fif.imemREN !== 1'b1 || wif.imemaddr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL reset_restart: got addr=%h ren=%b wrap_addr=%h, required 00000000 1 fffffffc",
                     fif.imemaddr, fif.imemREN, wif.imemaddr);
        end
        exp_pc = 32'h0;
        deliver(1, 32'h2008_0000);
    endtask

    initial begin
        test_reset();
        deliver(2, 32'h2001_0005);
        test_miss();
        deliver(1, 32'h2001_000C);
        test_stall();
        deliver(2, 32'h2001_0018);
        test_redirect_miss();
        test_redirect_latest_and_hit();
        test_halt();
        test_hold_redirect_and_halt();
        test_wrap_reset();
        next_cycle();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d undelivered words, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
